// File: rtl/synth_voice_allocator.sv
// Polyphonic voice allocator for the NCO piano synth.
// Assigns note events to voices, times each voice's release, and steals the oldest voice when every voice is busy.
module synth_voice_allocator #(
  parameter int N_VOICES       = 4,
  parameter int FCW_WIDTH      = 24,
  parameter int RELEASE_CYCLES = 1024,
  parameter int AGE_WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic                          note_on,
  input  logic [FCW_WIDTH-1:0]          note_fcw,
  input  logic                          all_notes_off,
  output logic [N_VOICES*FCW_WIDTH-1:0] voice_fcw,
  output logic [N_VOICES-1:0]           voice_gate,
  output logic [N_VOICES-1:0]           voice_busy,
  output logic [15:0]                   steal_count
);

  localparam int IDX_W = $clog2(N_VOICES);
  localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
  localparam logic [REL_W-1:0]     REL_LOAD = REL_W'(RELEASE_CYCLES);
  localparam logic [REL_W-1:0]     REL_ONE  = REL_W'(1);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX  = '1;

  typedef enum logic [1:0] {V_IDLE = 2'd0, V_ACTIVE = 2'd1, V_RELEASE = 2'd2} voice_state_t;
  typedef enum logic {ST_ACCEPT = 1'b0, ST_PROCESS = 1'b1} ctrl_state_t;

  ctrl_state_t            ctrl_r;
  logic                   ready_r;
  logic                   ev_on_r;
  logic [FCW_WIDTH-1:0]   ev_fcw_r;
  logic [15:0]            steal_r;
  voice_state_t           vstate_r [N_VOICES];
  logic [FCW_WIDTH-1:0]   fcw_r    [N_VOICES];
  logic [AGE_WIDTH-1:0]   age_r    [N_VOICES];
  logic [REL_W-1:0]       rel_r    [N_VOICES];
  logic [N_VOICES-1:0]    gate_r;
  logic [N_VOICES-1:0]    busy_r;

  voice_state_t           vstate_s [N_VOICES];
  logic [FCW_WIDTH-1:0]   fcw_s    [N_VOICES];
  logic [AGE_WIDTH-1:0]   age_s    [N_VOICES];
  logic [REL_W-1:0]       rel_s    [N_VOICES];
  logic                   apply_s, on_s, off_s, grow_s, do_steal_s;
  logic [N_VOICES-1:0]    idle_s, hit_s, off_hit_s;
  logic [IDX_W-1:0]       hit_idx_s, idle_idx_s, steal_idx_s, tgt_idx_s;
  logic [AGE_WIDTH-1:0]   best_age_s;

  function automatic logic [AGE_WIDTH-1:0] age_inc(input logic [AGE_WIDTH-1:0] a);
    return (a == AGE_MAX) ? a : a + AGE_WIDTH'(1);
  endfunction

  // Allocation decision, evaluated on pre-edge voice state.
  always_comb begin
    apply_s     = (ctrl_r == ST_PROCESS) && !all_notes_off;
    on_s        = apply_s && ev_on_r && (ev_fcw_r != '0);
    off_s       = apply_s && !ev_on_r;
    hit_idx_s   = '0;
    idle_idx_s  = '0;
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      idle_s[i]    = (vstate_r[i] == V_IDLE);
      hit_s[i]     = (vstate_r[i] != V_IDLE) && (fcw_r[i] == ev_fcw_r);
      off_hit_s[i] = (vstate_r[i] == V_ACTIVE) && (fcw_r[i] == ev_fcw_r);
      hit_idx_s    = hit_s[i] ? IDX_W'(i) : hit_idx_s;
      idle_idx_s   = idle_s[i] ? IDX_W'(i) : idle_idx_s;
    end
    // Strict '>' keeps the lowest index on age ties.
    steal_idx_s = '0;
    best_age_s  = age_r[0];
    for (int i = 1; i < N_VOICES; i++) begin
      steal_idx_s = (age_r[i] > best_age_s) ? IDX_W'(i) : steal_idx_s;
      best_age_s  = (age_r[i] > best_age_s) ? age_r[i] : best_age_s;
    end
    grow_s     = on_s && !(|hit_s);
    do_steal_s = grow_s && !(|idle_s);
    tgt_idx_s  = (|hit_s) ? hit_idx_s : ((|idle_s) ? idle_idx_s : steal_idx_s);
  end

  // Per-voice next state: event target, release entry, countdown, ageing.
  always_comb begin
    for (int i = 0; i < N_VOICES; i++) begin
      vstate_s[i] = vstate_r[i];
      fcw_s[i]    = fcw_r[i];
      age_s[i]    = ((vstate_r[i] != V_IDLE) && grow_s) ? age_inc(age_r[i]) : age_r[i];
      rel_s[i]    = rel_r[i];
      if (on_s && (tgt_idx_s == IDX_W'(i))) begin
        vstate_s[i] = V_ACTIVE;
        fcw_s[i]    = ev_fcw_r;
        age_s[i]    = '0;
        rel_s[i]    = '0;
      end else if ((vstate_r[i] == V_ACTIVE) && (all_notes_off || (off_s && off_hit_s[i]))) begin
        vstate_s[i] = V_RELEASE;
        rel_s[i]    = REL_LOAD;
      end else if ((vstate_r[i] == V_RELEASE) && (rel_r[i] == REL_ONE)) begin
        vstate_s[i] = V_IDLE;
        fcw_s[i]    = '0;
        age_s[i]    = '0;
        rel_s[i]    = '0;
      end else if (vstate_r[i] == V_RELEASE) begin
        rel_s[i]    = rel_r[i] - REL_ONE;
      end else begin
        rel_s[i]    = rel_r[i];
      end
    end
  end

  // Control FSM, steal counter and voice registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_r   <= ST_ACCEPT;
      ready_r  <= 1'b0;
      ev_on_r  <= 1'b0;
      ev_fcw_r <= '0;
      steal_r  <= 16'h0000;
      gate_r   <= '0;
      busy_r   <= '0;
      for (int i = 0; i < N_VOICES; i++) begin
        vstate_r[i] <= V_IDLE;
        fcw_r[i]    <= '0;
        age_r[i]    <= '0;
        rel_r[i]    <= '0;
      end
    end else begin
      case (ctrl_r)
        ST_ACCEPT: begin
          if (ready_r && note_valid) begin
            ev_on_r  <= note_on;
            ev_fcw_r <= note_fcw;
            ctrl_r   <= ST_PROCESS;
            ready_r  <= 1'b0;
          end else begin
            ready_r  <= 1'b1;
          end
        end
        ST_PROCESS: begin
          ctrl_r  <= ST_ACCEPT;
          ready_r <= 1'b1;
        end
        default: begin
          ctrl_r  <= ST_ACCEPT;
          ready_r <= 1'b0;
        end
      endcase
      if (do_steal_s && (steal_r != 16'hFFFF)) begin
        steal_r <= steal_r + 16'h0001;
      end
      for (int i = 0; i < N_VOICES; i++) begin
        vstate_r[i] <= vstate_s[i];
        fcw_r[i]    <= fcw_s[i];
        age_r[i]    <= age_s[i];
        rel_r[i]    <= rel_s[i];
        gate_r[i]   <= (vstate_s[i] == V_ACTIVE);
        busy_r[i]   <= (vstate_s[i] != V_IDLE);
      end
    end
  end

  // Flatten voice FCW registers onto the output bus.
  always_comb begin
    for (int i = 0; i < N_VOICES; i++) begin
      voice_fcw[i*FCW_WIDTH +: FCW_WIDTH] = fcw_r[i];
    end
  end

  assign note_ready  = ready_r;
  assign voice_gate  = gate_r;
  assign voice_busy  = busy_r;
  assign steal_count = steal_r;

endmodule

// File: tb/tb_synth_voice_allocator.sv
// Scoreboard bench for synth_voice_allocator (4 voices, 8-cycle release).
module tb_synth_voice_allocator;

  localparam int N  = 4;
  localparam int W  = 24;
  localparam int RC = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           note_valid = 1'b0;
  logic           note_ready;
  logic           note_on = 1'b0;
  logic [W-1:0]   note_fcw = '0;
  logic           all_notes_off = 1'b0;
  logic [N*W-1:0] voice_fcw;
  logic [N-1:0]   voice_gate;
  logic [N-1:0]   voice_busy;
  logic [15:0]    steal_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  gate;
    logic [3:0]  busy;
    logic [15:0] steal;
    logic [95:0] fcw;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  synth_voice_allocator #(
    .N_VOICES(N), .FCW_WIDTH(W), .RELEASE_CYCLES(RC), .AGE_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_ready(note_ready),
    .note_on(note_on), .note_fcw(note_fcw), .all_notes_off(all_notes_off),
    .voice_fcw(voice_fcw), .voice_gate(voice_gate), .voice_busy(voice_busy),
    .steal_count(steal_count)
  );

  function automatic logic [95:0] fv(input logic [23:0] v0, v1, v2, v3);
    return {v3, v2, v1, v0};
  endfunction

  function automatic exp_t mk(input logic [3:0] g, input logic [3:0] b,
                              input logic [15:0] s, input logic [95:0] f);
    exp_t e;
    e.gate = g; e.busy = b; e.steal = s; e.fcw = f;
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b0; note_valid = 1'b0; all_notes_off = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Handshake one event, push its expectation, check it at the decision edge.
  task automatic send(input logic on, input logic [23:0] fcw, input logic anoff, input exp_t e);
    exp_t got;
    int cyc = 0;
    exp_q.push_back(e);
    while (note_ready !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    vectors++;
    if (note_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_timeout: note_ready=%b required 1", note_ready);
    end
    note_valid = 1'b1; note_on = on; note_fcw = fcw;
    @(posedge clk); #1;
    note_valid = 1'b0; all_notes_off = anoff;
    vectors++;
    if (note_ready !== 1'b0) begin
      miscompares++; $display("FAIL ready_low: note_ready=%b required 0", note_ready);
    end
    @(posedge clk); #1;
    all_notes_off = 1'b0;
    got = exp_q.pop_front();
    vectors++;
    if (note_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_back: note_ready=%b required 1", note_ready);
    end
    vectors++;
    if (voice_gate !== got.gate) begin
      miscompares++; $display("FAIL gate fcw=%h: got %b required %b", fcw, voice_gate, got.gate);
    end
    vectors++;
    if (voice_busy !== got.busy) begin
      miscompares++; $display("FAIL busy fcw=%h: got %b required %b", fcw, voice_busy, got.busy);
    end
    vectors++;
    if (steal_count !== got.steal) begin
      miscompares++; $display("FAIL steal fcw=%h: got %0d required %0d", fcw, steal_count, got.steal);
    end
    vectors++;
    if (voice_fcw !== got.fcw) begin
      miscompares++; $display("FAIL voice_fcw fcw=%h: got %h required %h", fcw, voice_fcw, got.fcw);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if ({note_ready, voice_gate, voice_busy, steal_count, voice_fcw} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b gate=%b busy=%b steal=%0d fcw=%h required all 0",
               note_ready, voice_gate, voice_busy, steal_count, voice_fcw);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (note_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_ready: got %b required 1", note_ready);
    end
  endtask

  task automatic test_first_note();
    do_reset();
    send(1'b1, 24'h00A000, 1'b0, mk(4'b0001, 4'b0001, 16'd0, fv(24'h00A000, 24'h0, 24'h0, 24'h0)));
    send(1'b1, 24'h000000, 1'b0, mk(4'b0001, 4'b0001, 16'd0, fv(24'h00A000, 24'h0, 24'h0, 24'h0)));
  endtask

  task automatic test_steal();
    do_reset();
    send(1'b1, 24'h000100, 1'b0, mk(4'b0001, 4'b0001, 16'd0, fv(24'h100, 24'h0, 24'h0, 24'h0)));
    send(1'b1, 24'h000200, 1'b0, mk(4'b0011, 4'b0011, 16'd0, fv(24'h100, 24'h200, 24'h0, 24'h0)));
    send(1'b1, 24'h000300, 1'b0, mk(4'b0111, 4'b0111, 16'd0, fv(24'h100, 24'h200, 24'h300, 24'h0)));
    send(1'b1, 24'h000400, 1'b0, mk(4'b1111, 4'b1111, 16'd0, fv(24'h100, 24'h200, 24'h300, 24'h400)));
    send(1'b1, 24'h000500, 1'b0, mk(4'b1111, 4'b1111, 16'd1, fv(24'h500, 24'h200, 24'h300, 24'h400)));
    send(1'b1, 24'h000300, 1'b0, mk(4'b1111, 4'b1111, 16'd1, fv(24'h500, 24'h200, 24'h300, 24'h400)));
    // Oldest is now voice1 (age 3): retrigger of voice2 must not have aged anyone.
    send(1'b1, 24'h000600, 1'b0, mk(4'b1111, 4'b1111, 16'd2, fv(24'h500, 24'h600, 24'h300, 24'h400)));
  endtask

  task automatic test_release();
    logic [3:0] exp_b;
    do_reset();
    send(1'b1, 24'h000100, 1'b0, mk(4'b0001, 4'b0001, 16'd0, fv(24'h100, 24'h0, 24'h0, 24'h0)));
    send(1'b0, 24'h000777, 1'b0, mk(4'b0001, 4'b0001, 16'd0, fv(24'h100, 24'h0, 24'h0, 24'h0)));
    send(1'b0, 24'h000100, 1'b0, mk(4'b0000, 4'b0001, 16'd0, fv(24'h100, 24'h0, 24'h0, 24'h0)));
    for (int c = 1; c <= RC; c++) begin
      @(posedge clk); #1;
      exp_b = (c < RC) ? 4'b0001 : 4'b0000;
      vectors++;
      if (voice_busy !== exp_b) begin
        miscompares++; $display("FAIL release_busy cycle %0d: got %b required %b", c, voice_busy, exp_b);
      end
    end
    vectors++;
    if (voice_fcw !== '0) begin
      miscompares++; $display("FAIL release_fcw_clear: got %h required 0", voice_fcw);
    end
    send(1'b0, 24'h000777, 1'b0, mk(4'b0000, 4'b0000, 16'd0, fv(24'h0, 24'h0, 24'h0, 24'h0)));
  endtask

  task automatic test_retrigger_in_release();
    do_reset();
    send(1'b1, 24'h000100, 1'b0, mk(4'b0001, 4'b0001, 16'd0, fv(24'h100, 24'h0, 24'h0, 24'h0)));
    send(1'b0, 24'h000100, 1'b0, mk(4'b0000, 4'b0001, 16'd0, fv(24'h100, 24'h0, 24'h0, 24'h0)));
    repeat (3) @(posedge clk);
    #1;
    send(1'b1, 24'h000100, 1'b0, mk(4'b0001, 4'b0001, 16'd0, fv(24'h100, 24'h0, 24'h0, 24'h0)));
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      vectors++;
      if ({voice_gate, voice_busy} !== 8'b0001_0001) begin
        miscompares++;
        $display("FAIL retrigger_hold cycle %0d: gate=%b busy=%b required 0001/0001", c, voice_gate, voice_busy);
      end
    end
  endtask

  task automatic test_all_notes_off();
    logic [3:0] exp_b;
    do_reset();
    send(1'b1, 24'h000100, 1'b0, mk(4'b0001, 4'b0001, 16'd0, fv(24'h100, 24'h0, 24'h0, 24'h0)));
    send(1'b1, 24'h000200, 1'b0, mk(4'b0011, 4'b0011, 16'd0, fv(24'h100, 24'h200, 24'h0, 24'h0)));
    send(1'b1, 24'h000300, 1'b0, mk(4'b0111, 4'b0111, 16'd0, fv(24'h100, 24'h200, 24'h300, 24'h0)));
    send(1'b1, 24'h000900, 1'b1, mk(4'b0000, 4'b0111, 16'd0, fv(24'h100, 24'h200, 24'h300, 24'h0)));
    for (int c = 1; c <= RC; c++) begin
      @(posedge clk); #1;
      exp_b = (c < RC) ? 4'b0111 : 4'b0000;
      vectors++;
      if (voice_busy !== exp_b) begin
        miscompares++; $display("FAIL anoff_busy cycle %0d: got %b required %b", c, voice_busy, exp_b);
      end
    end
    vectors++;
    if (voice_fcw !== '0) begin
      miscompares++; $display("FAIL anoff_fcw_clear: got %h required 0", voice_fcw);
    end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_steal();
    test_release();
    test_retrigger_in_release();
    test_all_notes_off();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/synth_voice_allocator.md
Name: synth_voice_allocator

Overview:
- Polyphonic voice scheduler between the note-event source (CPU MMIO / UART command path) and N NCO voice datapaths of the hardware piano synth.
- Accepts note-on/note-off events over ready/valid and assigns each note to a voice, configuring that voice's frequency control word (FCW) and gate.
- Runs each voice's release timing.
- When all voices are busy, steals the oldest voice.

Parameters:
- N_VOICES, 4, number of NCO voices managed (2..8).
- FCW_WIDTH, 24, width of the NCO frequency control word.
- RELEASE_CYCLES, 1024, clk cycles a voice remains busy after note-off (>=1).
- AGE_WIDTH, 8, width of per-voice age counters (saturating).

Ports:
- clk  input  1  system clock (125 MHz).
- reset  input  1  synchronous, active-low reset: 0 = reset, sampled on the rising edge of clk.
- note_valid  input  1  event valid.
- note_ready  output  1  allocator can accept an event.
- note_on  input  1  1 = note-on, 0 = note-off.
- note_fcw  input  FCW_WIDTH  FCW identifying the note.
- all_notes_off  input  1  single-cycle pulse: release every ACTIVE voice.
- voice_fcw  output  N_VOICES*FCW_WIDTH  per-voice FCW, voice i at bits [i*FCW_WIDTH +: FCW_WIDTH].
- voice_gate  output  N_VOICES  1 while voice is ACTIVE.
- voice_busy  output  N_VOICES  1 while voice is ACTIVE or RELEASE.
- steal_count  output  16  number of voice steals, saturating at 16'hFFFF.

Behaviour:
- Per-voice state: IDLE, ACTIVE, RELEASE. Each voice also holds:
  - fcw register;
  - age (AGE_WIDTH, saturating);
  - release counter (width clog2(RELEASE_CYCLES+1)).
- Reset (reset==0 at an edge): all voices IDLE; fcw, age and release counter = 0; voice_gate = 0; voice_busy = 0; steal_count = 0; note_ready = 0.
  - note_ready rises at the first edge with reset==1.
  - Reset mid-operation discards any pending event.
- Control FSM: ACCEPT (note_ready=1), PROCESS (note_ready=0).
  - Handshake at edge k when note_ready && note_valid: event latched, FSM -> PROCESS.
  - At edge k+1 the decision is applied and FSM -> ACCEPT.
  - Result: voice outputs change at edge k+1; note_ready is high again after k+1; maximum throughput is one event per 2 cycles.
- Note-on decision, in strict priority order:
  - (a) note_fcw == 0: no-op.
  - (b) A busy voice whose fcw equals note_fcw: retrigger it. State -> ACTIVE, release counter cleared, age = 0, no other ages change.
  - (c) Otherwise, the lowest-index IDLE voice: fcw loaded, state -> ACTIVE, age = 0.
  - (d) Otherwise, steal the voice with the maximum age (ties: lowest index): fcw overwritten, state -> ACTIVE, age = 0, steal_count += 1.
- Ageing: in (c) and (d), every other busy voice's age increments by 1, saturating at 2^AGE_WIDTH-1.
- Note-off decision:
  - The ACTIVE voice with fcw == note_fcw -> RELEASE, release counter = RELEASE_CYCLES.
  - No match (including a match in RELEASE or IDLE): ignored.
  - At most one voice can match, guaranteed by rule (b).
- RELEASE timing:
  - Release counter decrements every cycle.
  - When it decrements 1 -> 0, the voice goes IDLE at that edge: fcw = 0, age = 0.
  - voice_fcw holds its value throughout RELEASE.
  - A voice entering RELEASE at edge t is IDLE at edge t+RELEASE_CYCLES.
- A voice that expires at the same edge as a PROCESS decision is not IDLE for that decision; decisions use pre-edge state.
- all_notes_off, sampled at an edge:
  - All ACTIVE voices -> RELEASE with counter = RELEASE_CYCLES.
  - Voices already in RELEASE continue their countdown unchanged.
  - If the FSM is in PROCESS at that edge, the pending event is discarded.
  - If asserted in ACCEPT together with a handshake, the event is still accepted, then processed normally in the following cycle.
- voice_gate and voice_busy are registered, decoded directly from voice state.

Test Plan:
- Parameters N_VOICES=4, RELEASE_CYCLES=8 throughout.
- Reset held 5 cycles, then released: all outputs 0 during reset; note_ready=1 one cycle after release.
- Note-on FCW 0x00A000: voice0 fcw = 0x00A000 and voice_gate = 4'b0001 two edges after the handshake; note_ready low for exactly 1 cycle.
- Note-on 0x100, 0x200, 0x300, 0x400, then 0x500 -> voice_gate = 4'b1111 and voice0 fcw = 0x500 (oldest stolen), steal_count = 1.
  - Then note-on 0x300 -> retrigger of voice2, no steal; steal_count stays 1.
- Note-on 0x100, then note-off 0x100 -> voice_gate = 0, voice_busy = 1 for exactly 8 cycles, then voice_busy = 0 and fcw = 0.
  - Note-off 0x777 (no match) -> no output change.
- During the release of 0x100, note-on 0x100 -> same voice returns to ACTIVE; voice_busy never drops.
- Three voices ACTIVE, all_notes_off pulsed in the PROCESS cycle of a note-on 0x900 -> all 3 voices enter RELEASE, 0x900 dropped; all voice_busy = 0 after 8 cycles.
